// File: rtl/janela_7taps.sv
`timescale 1ns/1ps
// ============================================================================
// janela_7taps
// ----------------------------------------------------------------------------
// Purpose:
//   Upstream feeder for the 7-tap filtroup interpolation filter. Converts a
//   raster pixel stream (one line at a time, in_last marks end of line) into
//   one 7-sample window per pixel, centred on that pixel. Taps are signed
//   DATA_WIDTH+2 values that drive filtroup in0..in6 directly.
//
//   Border handling:
//     default               : edge replication (first/last pixel repeated)
//     JANELA_ZERO_PAD_EN    : zero padding beyond both line edges
//
// Ports:
//   clk        in   clock, all state updates on rising edge
//   rst        in   synchronous active-high reset
//   in_valid   in   pixel present
//   in_ready   out  block accepts a pixel this cycle
//   in_data    in   unsigned pixel [DATA_WIDTH-1:0]
//   in_last    in   pixel is the last of its line
//   out_valid  out  window valid
//   out_ready  in   downstream consumes window
//   out_last   out  window is the last of its line
//   tap0..tap6 out  signed window, tap0 oldest, tap3 centre, tap6 newest
//   err_short  out  one-cycle pulse: a line shorter than 4 pixels was dropped
// ============================================================================
module janela_7taps #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [DATA_WIDTH-1:0]        in_data,
    input  logic                         in_last,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         out_last,
    output logic signed [DATA_WIDTH+1:0] tap0,
    output logic signed [DATA_WIDTH+1:0] tap1,
    output logic signed [DATA_WIDTH+1:0] tap2,
    output logic signed [DATA_WIDTH+1:0] tap3,
    output logic signed [DATA_WIDTH+1:0] tap4,
    output logic signed [DATA_WIDTH+1:0] tap5,
    output logic signed [DATA_WIDTH+1:0] tap6,
    output logic                         err_short
);

    localparam int TW = DATA_WIDTH + 2;
    // Shortest line that yields a full set of windows; tied to the 7-tap
    // geometry (centre plus three samples on each side).
    localparam int MIN_LINE = 4;

    typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_t;

    state_t               state_q, state_d;
    logic signed [TW-1:0] tap_q [7];
    logic signed [TW-1:0] tap_d [7];
    logic signed [TW-1:0] upper [6];
    logic                 out_valid_q, out_valid_d;
    logic                 out_last_q, out_last_d;
    logic                 err_short_q, err_short_d;
    logic [2:0]           fill_q, fill_d;
    logic [1:0]           flush_q, flush_d;

    logic                 adv;
    logic                 accept;
    logic signed [TW-1:0] in_tap;
    logic signed [TW-1:0] edge_tap;   // left-border fill on the first pixel
    logic signed [TW-1:0] flush_tap;  // right-border sample shifted in while flushing

    assign adv      = !out_valid_q || out_ready;
    assign in_ready = !rst && (state_q != FLUSH) && adv;
    assign accept   = in_valid && in_ready;
    assign in_tap   = $signed({2'b00, in_data});

    // Taps 0..5 of a shifted window are simply taps 1..6 of the current one.
    genvar gi;
    generate
        for (gi = 0; gi < 6; gi++) begin : g_shift
            assign upper[gi] = tap_q[gi+1];
        end
    endgenerate

`ifdef JANELA_ZERO_PAD_EN
    assign edge_tap  = '0;
    assign flush_tap = '0;
`else
    // Last pixel of the line, replicated into the window during flush.
    logic signed [TW-1:0] last_q, last_d;

    always_comb begin
        last_d = last_q;
        if (accept && in_last) begin
            last_d = in_tap;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= '0;
        end else begin
            last_q <= last_d;
        end
    end

    assign edge_tap  = in_tap;
    assign flush_tap = last_q;
`endif

    always_comb begin
        state_d     = state_q;
        tap_d       = tap_q;
        // A consumed window leaves the slot empty unless refilled below.
        out_valid_d = adv ? 1'b0 : out_valid_q;
        out_last_d  = adv ? 1'b0 : out_last_q;
        err_short_d = 1'b0;
        fill_d      = fill_q;
        flush_d     = flush_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    for (int j = 0; j < 6; j++) begin
                        tap_d[j] = edge_tap;
                    end
                    tap_d[6] = in_tap;
                    fill_d   = 3'd1;
                    if (in_last) begin
                        err_short_d = 1'b1;
                    end else begin
                        state_d = FILL;
                    end
                end
            end

            FILL: begin
                if (accept) begin
                    if (in_last && (fill_q < 3'(MIN_LINE - 1))) begin
                        // Too short: drop the line, window contents untouched.
                        err_short_d = 1'b1;
                        fill_d      = 3'd0;
                        state_d     = IDLE;
                    end else begin
                        for (int j = 0; j < 6; j++) begin
                            tap_d[j] = upper[j];
                        end
                        tap_d[6] = in_tap;
                        fill_d   = fill_q + 3'd1;
                        if (fill_q == 3'(MIN_LINE - 1)) begin
                            out_valid_d = 1'b1;
                            // A line of exactly MIN_LINE pixels goes straight to flush.
                            if (in_last) begin
                                flush_d = 2'd3;
                                state_d = FLUSH;
                            end else begin
                                state_d = RUN;
                            end
                        end
                    end
                end
            end

            RUN: begin
                if (accept) begin
                    for (int j = 0; j < 6; j++) begin
                        tap_d[j] = upper[j];
                    end
                    tap_d[6]    = in_tap;
                    out_valid_d = 1'b1;
                    if (in_last) begin
                        flush_d = 2'd3;
                        state_d = FLUSH;
                    end
                end
            end

            FLUSH: begin
                if (adv) begin
                    for (int j = 0; j < 6; j++) begin
                        tap_d[j] = upper[j];
                    end
                    tap_d[6]    = flush_tap;
                    out_valid_d = 1'b1;
                    flush_d     = flush_q - 2'd1;
                    if (flush_q == 2'd1) begin
                        out_last_d = 1'b1;
                        state_d    = IDLE;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            for (int j = 0; j < 7; j++) begin
                tap_q[j] <= '0;
            end
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            err_short_q <= 1'b0;
            fill_q      <= 3'd0;
            flush_q     <= 2'd0;
        end else begin
            state_q     <= state_d;
            tap_q       <= tap_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            err_short_q <= err_short_d;
            fill_q      <= fill_d;
            flush_q     <= flush_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign err_short = err_short_q;
    assign tap0      = tap_q[0];
    assign tap1      = tap_q[1];
    assign tap2      = tap_q[2];
    assign tap3      = tap_q[3];
    assign tap4      = tap_q[4];
    assign tap5      = tap_q[5];
    assign tap6      = tap_q[6];

endmodule

// File: tb/tb_janela_7taps.sv
`timescale 1ns/1ps
// Directed testbench for janela_7taps (DATA_WIDTH = 8).
module tb_janela_7taps;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [7:0]        in_data;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;
    logic signed [9:0] tap0, tap1, tap2, tap3, tap4, tap5, tap6;
    logic              err_short;
    logic [69:0]       taps_all;

    int checks = 0;
    int errors = 0;

    logic [7:0]  line_pix [0:7];
    logic [69:0] hand_w [0:4];

    janela_7taps #(.DATA_WIDTH(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
        .tap0(tap0), .tap1(tap1), .tap2(tap2), .tap3(tap3),
        .tap4(tap4), .tap5(tap5), .tap6(tap6),
        .err_short(err_short)
    );

    assign taps_all = {tap0, tap1, tap2, tap3, tap4, tap5, tap6};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [69:0] obs, input logic [69:0] exp);
        checks++;
        $display("check %0d %s: observed=%0h expected=%0h", checks, tag, obs, exp);
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [69:0] pk(input int a, input int b, input int c, input int d,
                                       input int e, input int f, input int g);
        return {10'(a), 10'(b), 10'(c), 10'(d), 10'(e), 10'(f), 10'(g)};
    endfunction

    // Reference window: centre pixel k of an n-pixel line held in line_pix.
    function automatic logic [69:0] model_win(input int n, input int k);
        logic [69:0] w;
        logic [9:0]  v;
        int          idx;
        w = '0;
        for (int j = 0; j < 7; j++) begin
            idx = k - 3 + j;
`ifdef JANELA_ZERO_PAD_EN
            if (idx < 0 || idx >= n) v = 10'd0;
            else                     v = {2'b00, line_pix[idx]};
`else
            if (idx < 0)       idx = 0;
            else if (idx >= n) idx = n - 1;
            v = {2'b00, line_pix[idx]};
`endif
            w[69-10*j -: 10] = v;
        end
        return w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one pixel, confirm it is acceptable, then let the edge take it.
    task automatic push(input logic [7:0] pix, input logic last);
        in_data  = pix;
        in_last  = last;
        in_valid = 1'b1;
        #1;
        chk("push_in_ready", 70'(in_ready), 70'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic check_win(input string tag, input int n, input int k, input logic exp_last);
        chk({tag, "_taps"}, taps_all, model_win(n, k));
        chk({tag, "_valid"}, 70'(out_valid), 70'd1);
        chk({tag, "_last"}, 70'(out_last), 70'(exp_last));
    endtask

    // Full line of n pixels from line_pix at out_ready=1, all windows checked.
    task automatic run_line(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            push(line_pix[i], (i == n - 1));
            if (i >= 3) check_win(tag, n, i - 3, 1'b0);
            else        chk({tag, "_fill_valid"}, 70'(out_valid), 70'd0);
        end
        for (int f = 1; f <= 3; f++) begin
            chk({tag, "_flush_in_ready"}, 70'(in_ready), 70'd0);
            tick();
            check_win(tag, n, n - 4 + f, (f == 3));
        end
        tick();
        chk({tag, "_end_valid"}, 70'(out_valid), 70'd0);
    endtask

    initial begin
`ifdef JANELA_ZERO_PAD_EN
        hand_w[0] = pk( 0,  0,  0, 10, 20, 30, 40);
        hand_w[1] = pk( 0,  0, 10, 20, 30, 40, 50);
        hand_w[2] = pk( 0, 10, 20, 30, 40, 50,  0);
        hand_w[3] = pk(10, 20, 30, 40, 50,  0,  0);
        hand_w[4] = pk(20, 30, 40, 50,  0,  0,  0);
`else
        hand_w[0] = pk(10, 10, 10, 10, 20, 30, 40);
        hand_w[1] = pk(10, 10, 10, 20, 30, 40, 50);
        hand_w[2] = pk(10, 10, 20, 30, 40, 50, 50);
        hand_w[3] = pk(10, 20, 30, 40, 50, 50, 50);
        hand_w[4] = pk(20, 30, 40, 50, 50, 50, 50);
`endif
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;

        // ---------------- reset state ----------------
        tick();
        tick();
        chk("rst_in_ready", 70'(in_ready), 70'd0);
        chk("rst_valid", 70'(out_valid), 70'd0);
        chk("rst_last", 70'(out_last), 70'd0);
        chk("rst_err", 70'(err_short), 70'd0);
        chk("rst_taps", taps_all, 70'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 70'(in_ready), 70'd1);

        // ---------------- line 10..50, hand-computed windows ----------------
        push(8'd10, 1'b0);
        chk("a_p0_valid", 70'(out_valid), 70'd0);
        push(8'd20, 1'b0);
        push(8'd30, 1'b0);
        chk("a_p2_valid", 70'(out_valid), 70'd0);
        push(8'd40, 1'b0);
        chk("a_w0", taps_all, hand_w[0]);
        chk("a_w0_valid", 70'(out_valid), 70'd1);
        chk("a_w0_last", 70'(out_last), 70'd0);
        push(8'd50, 1'b1);
        chk("a_w1", taps_all, hand_w[1]);
        chk("a_w1_last", 70'(out_last), 70'd0);
        chk("a_flush_in_ready", 70'(in_ready), 70'd0);
        tick();
        chk("a_w2", taps_all, hand_w[2]);
        chk("a_w2_last", 70'(out_last), 70'd0);
        tick();
        chk("a_w3", taps_all, hand_w[3]);
        chk("a_w3_last", 70'(out_last), 70'd0);
        tick();
        chk("a_w4", taps_all, hand_w[4]);
        chk("a_w4_valid", 70'(out_valid), 70'd1);
        chk("a_w4_last", 70'(out_last), 70'd1);
        chk("a_idle_in_ready", 70'(in_ready), 70'd1);
        tick();
        chk("a_end_valid", 70'(out_valid), 70'd0);
        chk("a_end_last", 70'(out_last), 70'd0);

        // ---------------- backpressure during RUN and FLUSH ----------------
        for (int i = 0; i < 6; i++) line_pix[i] = 8'(i + 1);
        for (int i = 0; i < 4; i++) push(line_pix[i], 1'b0);
        check_win("b_w0", 6, 0, 1'b0);
        out_ready = 1'b0;
        in_data   = line_pix[4];
        in_valid  = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("b_stall_in_ready", 70'(in_ready), 70'd0);
            tick();
            check_win("b_stall_w0", 6, 0, 1'b0);
        end
        out_ready = 1'b1;
        #1;
        chk("b_resume_in_ready", 70'(in_ready), 70'd1);
        tick();
        in_valid = 1'b0;
        check_win("b_w1", 6, 1, 1'b0);
        push(line_pix[5], 1'b1);
        check_win("b_w2", 6, 2, 1'b0);
        out_ready = 1'b0;
        tick();
        check_win("b_flush_stall_w2", 6, 2, 1'b0);
        out_ready = 1'b1;
        tick();
        check_win("b_w3", 6, 3, 1'b0);
        tick();
        check_win("b_w4", 6, 4, 1'b0);
        tick();
        check_win("b_w5", 6, 5, 1'b1);
        tick();
        chk("b_end_valid", 70'(out_valid), 70'd0);

        // ---------------- short line 5,6,7 then line 1..4 ----------------
        push(8'd5, 1'b0);
        chk("c_p0_err", 70'(err_short), 70'd0);
        push(8'd6, 1'b0);
        chk("c_p1_err", 70'(err_short), 70'd0);
        push(8'd7, 1'b1);
        chk("c_err_pulse", 70'(err_short), 70'd1);
        chk("c_err_valid", 70'(out_valid), 70'd0);
        tick();
        chk("c_err_clear", 70'(err_short), 70'd0);
        chk("c_err_valid2", 70'(out_valid), 70'd0);
        for (int i = 0; i < 4; i++) line_pix[i] = 8'(i + 1);
        run_line("c_line4", 4);
        chk("c_no_err", 70'(err_short), 70'd0);

        // ---------------- full-scale pixel stays positive ----------------
        line_pix[0] = 8'd255; line_pix[1] = 8'd1; line_pix[2] = 8'd2; line_pix[3] = 8'd255;
        for (int i = 0; i < 3; i++) push(line_pix[i], 1'b0);
        push(line_pix[3], 1'b1);
        check_win("d_w0", 4, 0, 1'b0);
        chk("d_tap3_255", 70'(tap3), 70'h0FF);
        chk("d_tap6_255", 70'(tap6), 70'h0FF);
        for (int f = 1; f <= 3; f++) begin
            tick();
            check_win("d_flush", 4, f, (f == 3));
        end
        tick();

        // ---------------- reset during FLUSH ----------------
        line_pix[0] = 8'd10; line_pix[1] = 8'd20; line_pix[2] = 8'd30;
        line_pix[3] = 8'd40; line_pix[4] = 8'd50;
        for (int i = 0; i < 4; i++) push(line_pix[i], 1'b0);
        push(line_pix[4], 1'b1);
        tick();
        check_win("e_w2", 5, 2, 1'b0);
        rst = 1'b1;
        tick();
        chk("e_rst_valid", 70'(out_valid), 70'd0);
        chk("e_rst_last", 70'(out_last), 70'd0);
        chk("e_rst_in_ready", 70'(in_ready), 70'd0);
        chk("e_rst_taps", taps_all, 70'd0);
        rst = 1'b0;
        tick();
        chk("e_after_valid", 70'(out_valid), 70'd0);
        chk("e_after_in_ready", 70'(in_ready), 70'd1);
        for (int i = 0; i < 4; i++) line_pix[i] = 8'(10 * i + 3);
        run_line("e_line4", 4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
